// File: rtl/atm_loader.sv
// -----------------------------------------------------------------------------
// atm_loader
//   Download-stage loader for Acorn .ATM images. Sits between the hps_io
//   ioctl_* byte stream and the shared 64 KB Atom RAM. It parses the header
//   (16-byte name, load, exec and length words, little-endian). It then
//   streams the body into RAM through a small FIFO and a req/gnt port. The
//   CPU is held off the RAM while a load is in progress.
//
//   Optional feature macro: ATM_AUTORUN_EN
//     When defined, the exec address is also written to AUTORUN_ADDR and
//     AUTORUN_ADDR+1 after the body. autorun pulses with load_done.
//     When undefined, autorun is tied to 0.
//
// Ports
//   clk_sys        in   system clock
//   reset_n        in   asynchronous active-low reset
//   ioctl_download in   download active
//   ioctl_index    in   [7:0]  file index (only FILE_INDEX is accepted)
//   ioctl_wr       in   one-cycle byte strobe
//   ioctl_addr     in   [24:0] byte offset within the file
//   ioctl_dout     in   [7:0]  byte data
//   mem_req        out  FIFO holds a byte for RAM
//   mem_gnt        in   arbiter grants the RAM port this cycle
//   ld_we          out  RAM write strobe
//   ld_addr        out  [15:0] RAM write address
//   ld_din         out  [7:0]  RAM write data
//   cpu_hold       out  stall CPU / select loader side of RAM mux
//   exec_addr      out  [15:0] exec address from header
//   load_done      out  one-cycle pulse on successful completion
//   err            out  [2:0] sticky {overrun, sequence, short}
//   autorun        out  one-cycle pulse with load_done (feature only)
// -----------------------------------------------------------------------------
module atm_loader #(
   parameter logic [7:0]  FILE_INDEX   = 8'd1,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [15:0] AUTORUN_ADDR = 16'h0052
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic        ld_we,
   output logic [15:0] ld_addr,
   output logic [7:0]  ld_din,
   output logic        cpu_hold,
   output logic [15:0] exec_addr,
   output logic        load_done,
   output logic [2:0]  err,
   output logic        autorun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_BODY, S_DRAIN, S_DONE, S_ERR
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_dl_q;
   logic [24:0] r_cnt;
   logic [15:0] r_load;
   logic [15:0] r_exec;
   logic [7:0]  r_len_lo;
   logic [15:0] r_ptr;
   logic [15:0] r_rem;
   logic [2:0]  r_err;
   logic        r_load_done;

   // FIFO: storage is data-only (not reset); pointers/count are control.
   logic [15:0] r_fa [FIFO_DEPTH];
   logic [7:0]  r_fd [FIFO_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_count;

   logic        w_start;
   logic        w_go;
   logic        w_fall;
   logic        w_acc;
   logic        w_wr_ok;
   logic        w_seq_bad;
   logic        w_hdr_end;
   logic        w_len0;
   logic        w_body_wr;
   logic        w_body_last;
   logic        w_pop;
   logic        w_can_push;
   logic        w_push;
   logic        w_ovr;
   logic        w_empty;
   logic        w_enter_done;
   logic [15:0] w_push_addr;
   logic [7:0]  w_push_data;

   logic        w_ar_push;
   logic        w_ar_done;
   logic        w_ar_sel;
   logic [15:0] w_ar_addr;
   logic [7:0]  w_ar_data;

   // Edge detection on ioctl_download; only the matching index starts a load.
   assign w_start = ioctl_download & ~r_dl_q & (ioctl_index == FILE_INDEX);
   assign w_go    = w_start & (r_state inside {S_IDLE, S_DONE, S_ERR});
   assign w_fall  = ~ioctl_download & r_dl_q;

   // A strobe is only considered in HDR/BODY; a falling download wins over it.
   assign w_acc       = ioctl_wr & ~w_fall & (r_state inside {S_HDR, S_BODY});
   assign w_wr_ok     = w_acc & (ioctl_addr == r_cnt);
   assign w_seq_bad   = w_acc & (ioctl_addr != r_cnt);
   assign w_hdr_end   = w_wr_ok & (r_state == S_HDR) & (r_cnt == 25'd21);
   assign w_len0      = ({ioctl_dout, r_len_lo} == 16'd0);
   assign w_body_wr   = w_wr_ok & (r_state == S_BODY);
   assign w_body_last = w_body_wr & (r_rem == 16'd1);

   assign w_empty    = (r_count == '0);
   assign mem_req    = ~w_empty;
   assign ld_we      = mem_req & mem_gnt;
   assign w_pop      = ld_we;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_can_push = (r_count != CW'(FIFO_DEPTH)) | w_pop;

   assign w_ar_addr   = AUTORUN_ADDR + {15'd0, w_ar_sel};
   assign w_ar_data   = w_ar_sel ? r_exec[15:8] : r_exec[7:0];
   assign w_push_addr = w_ar_push ? w_ar_addr : r_ptr;
   assign w_push_data = w_ar_push ? w_ar_data : ioctl_dout;

`ifdef ATM_AUTORUN_EN
   logic [1:0] r_ar_cnt;
   logic       r_autorun;

   // Two extra entries are queued once the body has completed.
   assign w_ar_push = (r_state == S_DRAIN) & ~r_ar_cnt[1] & w_can_push;
   assign w_ar_done = r_ar_cnt[1];
   assign w_ar_sel  = r_ar_cnt[0];
   assign autorun   = r_autorun;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_ar_cnt  <= 2'd0;
         r_autorun <= 1'b0;
      end else begin
         r_autorun <= w_enter_done;
         if (w_go)
            r_ar_cnt <= 2'd0;
         else if (w_ar_push)
            r_ar_cnt <= r_ar_cnt + 2'd1;
      end
   end
`else
   assign w_ar_push = 1'b0;
   assign w_ar_done = 1'b1;
   assign w_ar_sel  = 1'b0;
   assign autorun   = 1'b0;
`endif

   // Next-state and FIFO push control
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_ovr       = 1'b0;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (w_start) w_state_nxt = S_HDR;
         end
         S_HDR: begin
            if (w_fall || w_seq_bad) w_state_nxt = S_ERR;
            else if (w_hdr_end)      w_state_nxt = w_len0 ? S_DRAIN : S_BODY;
         end
         S_BODY: begin
            if (w_fall || w_seq_bad) w_state_nxt = S_ERR;
            else if (w_body_last)    w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!ioctl_download && w_empty && w_ar_done) w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_body_wr) begin
         if (w_can_push) w_push = 1'b1;
         else            w_ovr  = 1'b1;
      end
      if (w_ar_push) w_push = 1'b1;
   end

   assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Header capture, body pointer/length, error flags, FIFO control
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_dl_q      <= 1'b0;
         r_cnt       <= 25'd0;
         r_load      <= 16'd0;
         r_exec      <= 16'd0;
         r_len_lo    <= 8'd0;
         r_ptr       <= 16'd0;
         r_rem       <= 16'd0;
         r_err       <= 3'd0;
         r_load_done <= 1'b0;
         r_wp        <= '0;
         r_rp        <= '0;
         r_count     <= '0;
      end else begin
         r_dl_q      <= ioctl_download;
         r_load_done <= w_enter_done;

         if (w_go) begin
            r_err <= 3'd0;
            r_cnt <= 25'd0;
         end else if (w_wr_ok) begin
            r_cnt <= r_cnt + 25'd1;
         end

         if (w_wr_ok && r_state == S_HDR) begin
            case (r_cnt)
               25'd16:  r_load[7:0]  <= ioctl_dout;
               25'd17:  r_load[15:8] <= ioctl_dout;
               25'd18:  r_exec[7:0]  <= ioctl_dout;
               25'd19:  r_exec[15:8] <= ioctl_dout;
               25'd20:  r_len_lo     <= ioctl_dout;
               25'd21: begin
                  r_ptr <= r_load;
                  r_rem <= {ioctl_dout, r_len_lo};
               end
               default: ;
            endcase
         end

         // Pointer advances even for a dropped byte so later bytes keep their addresses.
         if (w_body_wr) begin
            r_ptr <= r_ptr + 16'd1;
            r_rem <= r_rem - 16'd1;
         end

         if (w_seq_bad) r_err[1] <= 1'b1;
         if (w_fall && (r_state inside {S_HDR, S_BODY})) r_err[0] <= 1'b1;
         if (w_ovr) r_err[2] <= 1'b1;

         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (w_push) begin
         r_fa[r_wp] <= w_push_addr;
         r_fd[r_wp] <= w_push_data;
      end
   end

   assign ld_addr   = mem_req ? r_fa[r_rp] : 16'd0;
   assign ld_din    = mem_req ? r_fd[r_rp] : 8'd0;
   // In ERR the CPU stays held until bytes already queued have reached RAM.
   assign cpu_hold  = (r_state inside {S_HDR, S_BODY, S_DRAIN}) ||
                      ((r_state == S_ERR) && mem_req);
   assign exec_addr = r_exec;
   assign load_done = r_load_done;
   assign err       = r_err;

endmodule
